test_monitor: RTL

//  Synthesizable end-of-test checker that sits directly downstream of riscv_soc in the sim top.

---
 rtl/test_monitor_pkg.sv | 32 +++
 rtl/test_monitor.sv | 111 +++++++++++
 2 files changed

// File: rtl/test_monitor_pkg.sv
// Shared types and default parameters for the end-of-test monitor.
package test_monitor_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned REG_AW             = 5;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 250;
  localparam int unsigned DEF_DRAIN_CYCLES   = 5;
  localparam int unsigned DEF_NUM_REG        = 3;
  localparam int unsigned DEF_DONE_REG       = 26;
  localparam int unsigned DEF_PASS_REG       = 27;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // One snooped register-file write.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_t;

  // Terminal states absorb until reset.
  function automatic logic is_terminal(state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/test_monitor.sv
// End-of-test checker: snoops regfile writes, shadows the test number and
// pass flag, and declares PASS, FAIL or TIMEOUT with sticky outputs.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int unsigned NUM_REG        = DEF_NUM_REG,
  parameter int unsigned DONE_REG       = DEF_DONE_REG,
  parameter int unsigned PASS_REG       = DEF_PASS_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [XLEN-1:0]   fail_num_o,
  output logic [XLEN-1:0]   cycle_cnt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e            state_q;
  wb_t               wb_q;
  logic [XLEN-1:0]   num_q;
  logic [XLEN-1:0]   pass_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0]  drain_cnt_q;
  logic              wr_ok;
  logic              trigger;

  // Register the writeback port once so the monitor never loads core timing paths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= '{we: we_i, addr: waddr_i, data: wdata_i};
  end

  // x0 writes are never architectural; shadows freeze once a verdict exists.
  assign wr_ok   = wb_q.we && (wb_q.addr != '0) && !is_terminal(state_q);
  assign trigger = wr_ok && (wb_q.addr == REG_AW'(DONE_REG)) && (wb_q.data == XLEN'(1));

  // Shadow copies of the test-number and pass-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q  <= '0;
      pass_q <= '0;
    end else if (wr_ok) begin
      if (wb_q.addr == REG_AW'(NUM_REG))  num_q  <= wb_q.data;
      if (wb_q.addr == REG_AW'(PASS_REG)) pass_q <= wb_q.data;
    end
  end

  // Verdict FSM with its run/drain counters and registered verdict outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      fail_num_o  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // A done-write on the last run cycle still wins over the timeout.
          if (trigger) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end else if (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= ST_TIMEOUT;
            done_o     <= 1'b1;
            timeout_o  <= 1'b1;
            fail_num_o <= num_q;
          end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          // Judge on the shadow as it stood before this edge.
          if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
            done_o     <= 1'b1;
            fail_num_o <= num_q;
            if (pass_q == XLEN'(1)) begin
              state_q <= ST_PASS;
              pass_o  <= 1'b1;
            end else begin
              state_q <= ST_FAIL;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running cycle count, saturating, frozen once a verdict exists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_o <= '0;
    end else if (!is_terminal(state_q) && (cycle_cnt_o != '1)) begin
      cycle_cnt_o <= cycle_cnt_o + XLEN'(1);
    end
  end

endmodule
